// File: rtl/attr_stream_fifo.sv
// Attribute ingress FIFO: unpacks multi-attribute beats into a circular buffer and
// serves single-attribute pops, reporting emptiness at whole-sample granularity.
module attr_stream_fifo #(
  parameter int ATTR_WIDTH     = 16,
  parameter int ATTRS_PER_BEAT = 2,
  parameter int ATTR_ABIT      = 5,
  parameter int FIFO_ABIT      = 6
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ATTRS_PER_BEAT*ATTR_WIDTH-1:0] i_s_data,
  input  logic                                 i_s_valid,
  output logic                                 o_s_ready,
  input  logic                                 i_s_last,
  input  logic [ATTR_ABIT-1:0]                 i_pop_amount,
  input  logic                                 i_flush,
  input  logic                                 i_fifo_pop,
  output logic [ATTR_WIDTH-1:0]                o_fifo_front,
  output logic                                 o_fifo_vld,
  output logic                                 o_fifo_is_empty,
  output logic [FIFO_ABIT:0]                   o_sample_cnt,
  output logic                                 o_err_len,
  output logic                                 o_err_underflow
);

  localparam int                 DEPTH   = 1 << FIFO_ABIT;
  localparam logic [FIFO_ABIT:0] DEPTH_C = (FIFO_ABIT+1)'(DEPTH);
  localparam logic [FIFO_ABIT:0] APB_C   = (FIFO_ABIT+1)'(ATTRS_PER_BEAT);
  localparam logic [FIFO_ABIT:0] ONE_F   = (FIFO_ABIT+1)'(1);

  logic [ATTR_WIDTH-1:0]     r_mem [DEPTH];
  logic [FIFO_ABIT-1:0]      r_wr_ptr;
  logic [FIFO_ABIT-1:0]      r_rd_ptr;
  logic [FIFO_ABIT:0]        r_fill;
  logic [ATTR_ABIT-1:0]      r_wr_idx;
  logic [ATTR_ABIT-1:0]      r_rd_idx;
  logic [FIFO_ABIT:0]        r_sample_cnt;
  logic [ATTR_WIDTH-1:0]     r_front_p1;
  logic                      r_vld_p1;
  logic                      r_err_len;
  logic                      r_err_uf;

  logic                      w_beat_acc;
  logic                      w_wr_done;
  logic [ATTRS_PER_BEAT-1:0] w_lane_en;
  logic [ATTR_ABIT-1:0]      w_wr_idx_nxt;
  logic [FIFO_ABIT:0]        w_lanes;
  logic                      w_pop_acc;
  logic                      w_rd_done;
  logic [FIFO_ABIT:0]        w_pop_dec;

  assign o_s_ready  = !rst && !i_flush && ((DEPTH_C - r_fill) >= APB_C);
  assign w_beat_acc = i_s_valid && o_s_ready;

  // Lanes after the one that closes a sample are dropped, so every sample begins on lane 0.
  always_comb begin
    w_lane_en    = '0;
    w_wr_done    = 1'b0;
    w_wr_idx_nxt = r_wr_idx;
    w_lanes      = '0;
    if (w_beat_acc) begin
      for (int l = 0; l < ATTRS_PER_BEAT; l++) begin
        if (!w_wr_done) begin
          w_lane_en[l] = 1'b1;
          w_lanes      = w_lanes + ONE_F;
          if (w_wr_idx_nxt == i_pop_amount) begin
            w_wr_done    = 1'b1;
            w_wr_idx_nxt = '0;
          end else begin
            w_wr_idx_nxt = w_wr_idx_nxt + ATTR_ABIT'(1);
          end
        end
      end
    end
  end

  assign w_pop_acc = i_fifo_pop && ((r_sample_cnt != '0) || (r_rd_idx != '0));
  assign w_rd_done = w_pop_acc && (r_rd_idx == i_pop_amount);
  assign w_pop_dec = {{FIFO_ABIT{1'b0}}, w_pop_acc};

  always_ff @(posedge clk) begin
    for (int l = 0; l < ATTRS_PER_BEAT; l++) begin
      if (w_lane_en[l]) begin
        r_mem[r_wr_ptr + FIFO_ABIT'(l)] <= i_s_data[l*ATTR_WIDTH +: ATTR_WIDTH];
      end
    end
  end

  // Stage p1: registered read port and all bookkeeping state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill       <= '0;
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_sample_cnt <= '0;
      r_front_p1   <= '0;
      r_vld_p1     <= 1'b0;
      r_err_len    <= 1'b0;
      r_err_uf     <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill       <= '0;
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_sample_cnt <= '0;
      r_vld_p1     <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_lanes[FIFO_ABIT-1:0];
      r_wr_idx <= w_wr_idx_nxt;
      r_fill   <= r_fill + w_lanes - w_pop_dec;
      r_vld_p1 <= w_pop_acc;
      if (w_pop_acc) begin
        r_front_p1 <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + FIFO_ABIT'(1);
        r_rd_idx   <= w_rd_done ? '0 : r_rd_idx + ATTR_ABIT'(1);
      end else if (i_fifo_pop) begin
        r_err_uf <= 1'b1;
      end
      if (w_wr_done && !w_rd_done) begin
        r_sample_cnt <= r_sample_cnt + ONE_F;
      end else if (!w_wr_done && w_rd_done) begin
        r_sample_cnt <= r_sample_cnt - ONE_F;
      end
      if (w_beat_acc && (w_wr_done != i_s_last)) begin
        r_err_len <= 1'b1;
      end
    end
  end

  assign o_fifo_front    = r_front_p1;
  assign o_fifo_vld      = r_vld_p1;
  assign o_sample_cnt    = r_sample_cnt;
  assign o_fifo_is_empty = (r_sample_cnt == '0);
  assign o_err_len       = r_err_len;
  assign o_err_underflow = r_err_uf;

endmodule

// File: tb/tb_attr_stream_fifo.sv
// Bench for attr_stream_fifo: directed scenarios then randomized traffic, each cycle
// checked against a queue-based model of the attribute stream.
module tb_attr_stream_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_s_data;
  logic        i_s_valid;
  logic        o_s_ready;
  logic        i_s_last;
  logic [4:0]  i_pop_amount;
  logic        i_flush;
  logic        i_fifo_pop;
  logic [15:0] o_fifo_front;
  logic        o_fifo_vld;
  logic        o_fifo_is_empty;
  logic [6:0]  o_sample_cnt;
  logic        o_err_len;
  logic        o_err_underflow;

  attr_stream_fifo dut (
    .clk(clk), .rst(rst), .i_s_data(i_s_data), .i_s_valid(i_s_valid),
    .o_s_ready(o_s_ready), .i_s_last(i_s_last), .i_pop_amount(i_pop_amount),
    .i_flush(i_flush), .i_fifo_pop(i_fifo_pop), .o_fifo_front(o_fifo_front),
    .o_fifo_vld(o_fifo_vld), .o_fifo_is_empty(o_fifo_is_empty),
    .o_sample_cnt(o_sample_cnt), .o_err_len(o_err_len),
    .o_err_underflow(o_err_underflow)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // Model: attributes held in order, plus how far into the current sample each side is.
  logic [15:0] m_q[$];
  int          m_wcnt, m_rcnt, m_scnt;
  bit          m_err_len, m_err_uf, m_vld;
  logic [15:0] m_front;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [31:0] d, input bit lst,
                      input bit p, input bit f);
    bit exp_rdy, acc, done, rd_done;
    int pa;
    @(negedge clk);
    rst = r; i_s_valid = v; i_s_data = d; i_s_last = lst; i_fifo_pop = p; i_flush = f;
    #1;
    exp_rdy = !r && !f && ((64 - m_q.size()) >= 2);
    chk("ready", o_s_ready, exp_rdy);
    @(posedge clk);
    pa = int'(i_pop_amount);
    if (r) begin
      m_q.delete(); m_wcnt = 0; m_rcnt = 0; m_scnt = 0;
      m_err_len = 0; m_err_uf = 0; m_vld = 0; m_front = '0;
    end else if (f) begin
      m_q.delete(); m_wcnt = 0; m_rcnt = 0; m_scnt = 0; m_vld = 0;
    end else begin
      rd_done = 0;
      acc = p && (m_scnt != 0 || m_rcnt != 0);
      m_vld = acc;
      if (acc) begin
        m_front = m_q.pop_front();
        m_rcnt++;
        if (m_rcnt == pa + 1) begin m_rcnt = 0; rd_done = 1; end
      end else if (p) m_err_uf = 1;
      done = 0;
      if (v && exp_rdy) begin
        for (int l = 0; l < 2 && !done; l++) begin
          m_q.push_back(d[l*16 +: 16]);
          m_wcnt++;
          if (m_wcnt == pa + 1) begin m_wcnt = 0; done = 1; end
        end
        if (done != lst) m_err_len = 1;
      end
      m_scnt = m_scnt + int'(done) - int'(rd_done);
    end
    #1;
    chk("vld", o_fifo_vld, m_vld);
    chk("front", o_fifo_front, m_front);
    chk("cnt", o_sample_cnt, m_scnt);
    chk("empty", o_fifo_is_empty, m_scnt == 0);
    chk("err_len", o_err_len, m_err_len);
    chk("err_uf", o_err_underflow, m_err_uf);
  endtask

  task automatic idle();  step(0, 0, 32'h0, 0, 0, 0); endtask
  task automatic pop();   step(0, 0, 32'h0, 0, 1, 0); endtask
  task automatic flush(); step(0, 0, 32'h0, 0, 0, 1); endtask
  task automatic beat(input logic [31:0] d, input bit lst); step(0, 1, d, lst, 0, 0); endtask

  initial begin
    rst = 1; i_s_data = '0; i_s_valid = 0; i_s_last = 0; i_fifo_pop = 0; i_flush = 0;
    i_pop_amount = 5'd3;
    m_q.delete(); m_wcnt = 0; m_rcnt = 0; m_scnt = 0;
    m_err_len = 0; m_err_uf = 0; m_vld = 0; m_front = '0;

    // Reset state
    step(1, 1, 32'hDEAD_BEEF, 0, 0, 0);
    step(1, 0, 32'h0, 0, 0, 0);
    idle();
    chk("rst_cnt", o_sample_cnt, 7'd0);
    chk("rst_empty", o_fifo_is_empty, 1'b1);

    // Two samples of four
    beat({16'hA001, 16'hA000}, 0);
    beat({16'hA003, 16'hA002}, 1);
    chk("two_cnt1", o_sample_cnt, 7'd1);
    beat({16'hB001, 16'hB000}, 0);
    beat({16'hB003, 16'hB002}, 1);
    chk("two_cnt2", o_sample_cnt, 7'd2);
    for (int i = 0; i < 4; i++) pop();
    chk("two_lastA3", o_fifo_front, 16'hA003);
    idle();
    chk("two_cnt_after", o_sample_cnt, 7'd1);

    // Odd length: high lane of the closing beat is dropped
    flush();
    i_pop_amount = 5'd2;
    beat({16'hFFFF, 16'hC000 + 16'h0}, 0);
    beat({16'hEEEE, 16'hC002}, 1);
    beat({16'hD001, 16'hD000}, 0);
    beat({16'hEEEE, 16'hD002}, 1);
    for (int i = 0; i < 3; i++) pop();
    chk("odd_front", o_fifo_front, 16'hC002);
    pop();
    chk("odd_next", o_fifo_front, 16'hD000);
    pop(); pop(); idle();
    chk("odd_err_len", o_err_len, 1'b0);

    // Underflow with nothing stored
    pop();
    chk("uf_vld", o_fifo_vld, 1'b0);
    chk("uf_flag", o_err_underflow, 1'b1);

    // Full, pointer wrap, drain
    flush();
    i_pop_amount = 5'd3;
    for (int i = 0; i < 32; i++) beat($urandom, i[0]);
    idle();
    chk("full_ready", o_s_ready, 1'b0);
    pop(); pop();
    beat({16'h7001, 16'h7000}, 0);
    pop(); pop();
    beat({16'h7003, 16'h7002}, 1);
    for (int i = 0; i < 66; i++) pop();
    idle();

    // Sample B completes while A's last attribute is popped
    flush();
    beat({16'h1101, 16'h1100}, 0);
    beat({16'h1103, 16'h1102}, 1);
    beat({16'h2201, 16'h2200}, 0);
    pop(); pop(); pop();
    step(0, 1, {16'h2203, 16'h2202}, 1, 1, 0);
    chk("sim_cnt", o_sample_cnt, 7'd1);
    beat({16'h3301, 16'h3300}, 0);
    step(0, 1, {16'h3303, 16'h3302}, 1, 0, 1);
    chk("flush_cnt", o_sample_cnt, 7'd0);
    chk("flush_empty", o_fifo_is_empty, 1'b1);
    chk("flush_uf_kept", o_err_underflow, 1'b1);
    idle();

    // Early last flag
    beat({16'h4401, 16'h4400}, 1);
    chk("len_err", o_err_len, 1'b1);
    beat({16'h4403, 16'h4402}, 1);
    chk("len_cnt", o_sample_cnt, 7'd1);
    for (int i = 0; i < 4; i++) pop();
    idle();

    // Randomized traffic
    step(1, 0, 32'h0, 0, 0, 0);
    for (int rnd = 0; rnd < 4; rnd++) begin
      flush();
      i_pop_amount = 5'($urandom_range(0, 7));
      for (int c = 0; c < 400; c++) begin
        int  rem;
        bit  lst;
        rem = int'(i_pop_amount) + 1 - m_wcnt;
        lst = (rem <= 2) ^ ($urandom_range(0, 19) == 0);
        step(0, $urandom_range(0, 2) != 0, $urandom, lst, $urandom_range(0, 2) == 0, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
